// File: rtl/gate_truth_checker.sv
// Sweeps all four {a,b} vectors into a 2-input gate, samples its output c
// after a settle delay and compares the observed truth table with EXPECTED.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [3:0] mismatch,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] obs_q, obs_d;
    logic [3:0] mis_q, mis_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            obs_q   <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            obs_q   <= obs_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        obs_d   = obs_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    vec_d   = '0;
                    obs_d   = '0;
                    mis_d   = '0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                obs_d[vec_q] = c;
                mis_d[vec_q] = c ^ EXPECTED[vec_q];
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    // {a,b} follow vec_idx, so the next vector is driven on this edge
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a        = vec_q[1];
    assign b        = vec_q[0];
    assign vec_idx  = vec_q;
    assign observed = obs_q;
    assign mismatch = mis_q;
    assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign pass     = (state_q == DONE) && (mis_q == 4'b0000);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: gate models drive c, a monitor checks each completed sweep.
module tb_gate_truth_checker;

    localparam int G_IMP  = 0;
    localparam int G_AND  = 1;
    localparam int G_OR   = 2;
    localparam int G_ZERO = 3;

    typedef struct {
        logic [3:0] obs;
        logic [3:0] mis;
        logic       pass;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       c0, c1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] obs0, mis0, obs1, mis1;
    logic [1:0] vec0, vec1;

    int mode0 = G_IMP;
    int mode1 = G_OR;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st0 = 0;
    int st1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gate_fn(input int m, input logic x, input logic y);
        case (m)
            G_IMP:   return ~x | y;
            G_AND:   return x & y;
            G_OR:    return x | y;
            default: return 1'b0;
        endcase
    endfunction

    assign c0 = gate_fn(mode0, a0, b0);
    assign c1 = gate_fn(mode1, a1, b1);

    gate_truth_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .c(c0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .observed(obs0), .mismatch(mis0), .vec_idx(vec0)
    );

    gate_truth_checker #(.SETTLE_CYCLES(1), .EXPECTED(4'b1110)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .c(c1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .observed(obs1), .mismatch(mis1), .vec_idx(vec1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per rising done
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    always @(negedge clk) begin
        prev0 <= done0;
        prev1 <= done1;
        if (busy0 && pass0) chk("pass_while_busy0", 1, 0);
        if (busy1 && pass1) chk("pass_while_busy1", 1, 0);
        if (done0 && !prev0) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("observed0", 32'(obs0), 32'(e.obs));
                chk("mismatch0", 32'(mis0), 32'(e.mis));
                chk("pass0", 32'(pass0), 32'(e.pass));
                chk("latency0", 32'(cyc - st0), 32'(e.lat));
            end
        end
        if (done1 && !prev1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("observed1", 32'(obs1), 32'(e.obs));
                chk("mismatch1", 32'(mis1), 32'(e.mis));
                chk("pass1", 32'(pass1), 32'(e.pass));
                chk("latency1", 32'(cyc - st1), 32'(e.lat));
            end
        end
    end

    task automatic push0(input logic [3:0] o, input logic [3:0] m,
                         input logic p, input int l);
        exp_t e;
        e.obs = o; e.mis = m; e.pass = p; e.lat = l;
        q0.push_back(e);
    endtask

    task automatic pulse0(input bit record);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        if (record) st0 = cyc;
        start0 = 1'b0;
    endtask

    task automatic drain(input int which);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((which == 0 ? q0.size() : q1.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (!ok) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({a0, b0, busy0, done0, pass0, obs0, mis0, vec0}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_busy", 32'({busy0, done0}), 0);

        // Implication gate, default parameters
        mode0 = G_IMP;
        push0(4'b1011, 4'b0000, 1'b1, 12);
        pulse0(1);
        chk("accept_state", 32'({busy0, done0, pass0, vec0}), 32'b10000);
        drain(0);
        chk("done_holds_11", 32'({a0, b0, busy0, done0}), 32'b1101);

        // AND gate against implication table, started from DONE
        mode0 = G_AND;
        push0(4'b1000, 4'b0011, 1'b0, 12);
        pulse0(1);
        chk("restart_clear", 32'({obs0, mis0, done0, busy0}), 32'b1);
        drain(0);

        // Second start mid-sweep must be ignored
        mode0 = G_IMP;
        push0(4'b1011, 4'b0000, 1'b1, 12);
        pulse0(1);
        repeat (3) @(posedge clk);
        pulse0(0);
        drain(0);
        repeat (20) @(negedge clk);
        chk("single_sweep_done", 32'({done0, busy0}), 32'b10);

        // Reset during SETTLE of vector 2
        pulse0(1);
        repeat (7) @(posedge clk);
        #1;
        chk("in_vec2", 32'({vec0, busy0}), 32'b101);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset",
            32'({a0, b0, busy0, done0, pass0, obs0, mis0, vec0}), 0);
        @(negedge clk);
        rst = 1'b0;
        push0(4'b1011, 4'b0000, 1'b1, 12);
        pulse0(1);
        drain(0);

        // SETTLE_CYCLES=1 instance with OR gate
        mode1 = G_OR;
        begin
            exp_t e;
            e.obs = 4'b1110; e.mis = 4'b0000; e.pass = 1'b1; e.lat = 8;
            q1.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = cyc;
        start1 = 1'b0;
        drain(1);

        // Restart from DONE with c stuck at 0
        mode0 = G_ZERO;
        push0(4'b0000, 4'b1011, 1'b0, 12);
        pulse0(1);
        chk("zero_restart_clear", 32'({obs0, mis0, pass0}), 0);
        drain(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
